// File: rtl/control_unit.sv
// Timestep sequencer and instruction decoder for the 10-bit bus datapath.
// Optional build macro CTRL_SINGLE_STEP_EN: T1..T3 advance only on a STEP pulse.
module control_unit #(
    parameter int DATA_W = 10,
    parameter int NREG   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] INSTR,
    input  logic              EXEC,
    input  logic              STEP,
    output logic [1:0]        TIME,
    output logic              DONE,
    output logic [NREG-1:0]   RIN,
    output logic [NREG-1:0]   ROUT,
    output logic              DIN_OUT,
    output logic              A_IN,
    output logic              G_IN,
    output logic              G_OUT,
    output logic              ADDSUB
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;

    logic [1:0]        state_q, state_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              exec_q, exec_d;
    logic              exec_prev_q, exec_prev_d;

    logic [1:0]      opcode, rx, ry;
    logic [NREG-1:0] x_onehot, y_onehot;
    logic            exec_edge;
    logic            advance;
    logic            unused_bits;

    assign opcode    = ir_q[DATA_W-1 -: 2];
    assign rx        = ir_q[7:6];
    assign ry        = ir_q[5:4];
    assign exec_edge = exec_q & ~exec_prev_q;
    assign TIME      = state_q;
    assign DONE      = done_q;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign x_onehot[gi] = (rx == 2'(gi));
            assign y_onehot[gi] = (ry == 2'(gi));
        end
    endgenerate

`ifdef CTRL_SINGLE_STEP_EN
    // Leaving T1..T3 and every load enable are tied to the STEP cycle, so each step commits once.
    assign advance     = STEP;
    assign unused_bits = ^ir_q[3:0];
`else
    assign advance     = 1'b1;
    assign unused_bits = ^{STEP, ir_q[3:0]};
`endif

    always_comb begin
        exec_d      = EXEC;
        exec_prev_d = exec_q;
        state_d     = state_q;
        done_d      = done_q;
        ir_d        = ir_q;
        RIN         = '0;
        ROUT        = '0;
        DIN_OUT     = 1'b0;
        A_IN        = 1'b0;
        G_IN        = 1'b0;
        G_OUT       = 1'b0;
        ADDSUB      = 1'b0;
        case (state_q)
            T0: begin
                if (exec_edge) begin
                    ir_d    = INSTR;
                    done_d  = 1'b0;
                    state_d = T1;
                end
            end
            T1: begin
                if (opcode == OP_LOAD || opcode == OP_MOV) begin
                    if (opcode == OP_LOAD) DIN_OUT = 1'b1;
                    else                   ROUT    = y_onehot;
                    RIN = advance ? x_onehot : '0;
                    if (advance) begin
                        done_d  = 1'b1;
                        state_d = T0;
                    end
                end else begin
                    ROUT = x_onehot;
                    A_IN = advance;
                    if (advance) state_d = T2;
                end
            end
            T2: begin
                ROUT   = y_onehot;
                G_IN   = advance;
                ADDSUB = opcode[0];
                if (advance) state_d = T3;
            end
            default: begin
                G_OUT = 1'b1;
                RIN   = advance ? x_onehot : '0;
                if (advance) begin
                    done_d  = 1'b1;
                    state_d = T0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= T0;
            done_q      <= 1'b0;
            ir_q        <= '0;
            // Both edge stages track the level during reset so a held EXEC sees no rising edge.
            exec_q      <= EXEC;
            exec_prev_q <= EXEC;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            ir_q        <= ir_d;
            exec_q      <= exec_d;
            exec_prev_q <= exec_prev_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-cycle control words for each
// opcode plus reset, ignored-EXEC, mid-instruction reset and STEP sequences.
module tb_control_unit;

    logic       clk, rst, exec_i, step_i;
    logic [9:0] instr_i;
    logic [1:0] time_o;
    logic       done_o, din_out_o, a_in_o, g_in_o, g_out_o, addsub_o;
    logic [3:0] rin_o, rout_o;

    int vectors  = 0;
    int miscount = 0;

`ifdef CTRL_SINGLE_STEP_EN
    localparam logic STEP_IDLE = 1'b1;
`else
    localparam logic STEP_IDLE = 1'b0;
`endif

    control_unit #(.DATA_W(10), .NREG(4)) dut (
        .CLK(clk), .RST(rst), .INSTR(instr_i), .EXEC(exec_i), .STEP(step_i),
        .TIME(time_o), .DONE(done_o), .RIN(rin_o), .ROUT(rout_o),
        .DIN_OUT(din_out_o), .A_IN(a_in_o), .G_IN(g_in_o), .G_OUT(g_out_o),
        .ADDSUB(addsub_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {TIME, DONE, RIN, ROUT, DIN_OUT, A_IN, G_IN, G_OUT, ADDSUB}
    function automatic logic [15:0] ctl(input logic [1:0] t, input logic d,
                                        input logic [3:0] rin, input logic [3:0] rout,
                                        input logic din, input logic ain, input logic gin,
                                        input logic gout, input logic asub);
        return {t, d, rin, rout, din, ain, gin, gout, asub};
    endfunction

    typedef struct {
        logic [9:0]       instr;
        int               n;
        logic [2:0][15:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [9:0] instr, input int n,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2);
        vec_t v;
        v.instr  = instr;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        return v;
    endfunction

    // ADDSUB only matters while G_IN is expected high.
    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] act, m;
        act = {time_o, done_o, rin_o, rout_o, din_out_o, a_in_o, g_in_o, g_out_o, addsub_o};
        m   = exp[2] ? 16'hFFFF : 16'hFFFE;
        vectors++;
        if ((act & m) !== (exp & m)) begin
            miscount++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic start(input logic [9:0] instr);
        instr_i = instr;
        exec_i  = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    vec_t        vecs [8];
    logic [15:0] z, done_w;

    initial begin
        z      = 16'h0000;
        done_w = ctl(2'd0, 1'b1, 4'b0, 4'b0, 0, 0, 0, 0, 0);
        vecs[0] = mk(10'b00_01_101010, 1, ctl(1, 0, 4'b0010, 4'b0000, 1, 0, 0, 0, 0), z, z);
        vecs[1] = mk(10'b01_11_10_0000, 1, ctl(1, 0, 4'b1000, 4'b0100, 0, 0, 0, 0, 0), z, z);
        vecs[2] = mk(10'b10_00_01_0000, 3, ctl(1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0, 0),
                     ctl(2, 0, 4'b0000, 4'b0010, 0, 0, 1, 0, 0),
                     ctl(3, 0, 4'b0001, 4'b0000, 0, 0, 0, 1, 0));
        vecs[3] = mk(10'b11_10_10_0000, 3, ctl(1, 0, 4'b0000, 4'b0100, 0, 1, 0, 0, 0),
                     ctl(2, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, 1),
                     ctl(3, 0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0));
        vecs[4] = mk(10'b10_01_01_1111, 3, ctl(1, 0, 4'b0000, 4'b0010, 0, 1, 0, 0, 0),
                     ctl(2, 0, 4'b0000, 4'b0010, 0, 0, 1, 0, 0),
                     ctl(3, 0, 4'b0010, 4'b0000, 0, 0, 0, 1, 0));
        vecs[5] = mk(10'b00_00_111111, 1, ctl(1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0, 0), z, z);
        vecs[6] = mk(10'b01_00_11_0101, 1, ctl(1, 0, 4'b0001, 4'b1000, 0, 0, 0, 0, 0), z, z);
        vecs[7] = mk(10'b11_11_00_0000, 3, ctl(1, 0, 4'b0000, 4'b1000, 0, 1, 0, 0, 0),
                     ctl(2, 0, 4'b0000, 4'b0001, 0, 0, 1, 0, 1),
                     ctl(3, 0, 4'b1000, 4'b0000, 0, 0, 0, 1, 0));

        // Reset with EXEC held high: no instruction may start.
        rst = 1'b1; exec_i = 1'b1; step_i = STEP_IDLE; instr_i = 10'b00_11_000001;
        repeat (2) @(negedge clk);
        check("reset", z);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no_start_after_reset c%0d", i), z);
        end
        exec_i = 1'b0;
        @(negedge clk);

        // Table of single instructions, one state per clock.
        step_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start(vecs[i].instr);
            for (int s = 0; s < vecs[i].n; s++) begin
                check($sformatf("vec%0d t%0d", i, s + 1), vecs[i].exp[s]);
                if (s == 0) exec_i = 1'b0;
                @(negedge clk);
            end
            check($sformatf("vec%0d done", i), done_w);
        end
        step_i = STEP_IDLE;
        @(negedge clk);

        // SUB R2,R2 with a second EXEC edge arriving in T2: ignored, no restart.
        start(10'b11_10_10_0000);
        check("sub_rr t1", ctl(1, 0, 4'b0000, 4'b0100, 0, 1, 0, 0, 0));
        exec_i = 1'b0;
        @(negedge clk);
        check("sub_rr t2", ctl(2, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, 1));
        instr_i = 10'b00_11_000001;
        exec_i  = 1'b1;
        @(negedge clk);
        check("sub_rr t3", ctl(3, 0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0));
        @(negedge clk);
        check("sub_rr done", done_w);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("sub_rr no_restart c%0d", i), done_w);
        end
        exec_i = 1'b0;
        @(negedge clk);

        // Reset during T2 of ADD: back to idle, G_OUT/RIN never asserted.
        start(10'b10_00_01_0000);
        check("add_rst t1", ctl(1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0, 0));
        exec_i = 1'b0;
        @(negedge clk);
        check("add_rst t2", ctl(2, 0, 4'b0000, 4'b0010, 0, 0, 1, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        check("add_rst in_reset", z);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("add_rst idle c%0d", i), z);
        end

`ifdef CTRL_SINGLE_STEP_EN
        // STEP pulses three cycles apart: states hold, enables fire only with STEP.
        step_i = 1'b0;
        start(10'b10_00_01_0000);
        exec_i = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            for (int c = 0; c < 3; c++) begin
                logic p;
                logic [15:0] e;
                p = (c == 2);
                step_i = p;
                #1;
                if (t == 1)      e = ctl(2'(t), 0, 4'b0000, 4'b0001, 0, p, 0, 0, 0);
                else if (t == 2) e = ctl(2'(t), 0, 4'b0000, 4'b0010, 0, 0, p, 0, 0);
                else             e = ctl(2'(t), 0, p ? 4'b0001 : 4'b0000, 4'b0000, 0, 0, 0, 1, 0);
                check($sformatf("step t%0d c%0d", t, c), e);
                @(negedge clk);
            end
        end
        step_i = 1'b0;
        #1;
        check("step done", done_w);
`else
        // STEP toggling has no effect in the free-running build.
        step_i = 1'b0;
        start(10'b10_00_01_0000);
        exec_i = 1'b0;
        check("nostep t1", ctl(1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0, 0));
        step_i = 1'b1;
        @(negedge clk);
        check("nostep t2", ctl(2, 0, 4'b0000, 4'b0010, 0, 0, 1, 0, 0));
        step_i = 1'b0;
        @(negedge clk);
        check("nostep t3", ctl(3, 0, 4'b0001, 4'b0000, 0, 0, 0, 1, 0));
        @(negedge clk);
        check("nostep done", done_w);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscount);
        $finish;
    end

endmodule
